// File: rtl/run_sequencer.sv
// run_sequencer: run controller for the UART-loaded multi-core matrix processor.
// Sequences instruction load, data load, execution and result readback, arbitrates
// the shared instruction/data memory ports, captures the Q/R address words,
// and guards every active phase with a watchdog.
//
// Ports:
//   clk, rstN                 clock, asynchronous active-low reset
//   start, reload_imem        run request pulse and reload selector (sampled from DONE/ERROR)
//   rx_byte_valid             UART byte strobe, routed to the active loader
//   *_rx_done, proc_done,
//   dmem_tx_done              phase completion pulses
//   uart_imem_*, proc_imem_*  instruction memory port sources
//   uart_dmem_*, proc_dmem_*  data memory port sources
//   imem_*, dmem_*            muxed memory ports (combinational)
//   proc_start, tx_start      combinational start pulses
//   rx_end_addr, tx_start_addr,
//   tx_end_addr               captured address words
//   state, busy, error        controller status
//   run_time, run_count       saturating execution timer, completed-run counter
module run_sequencer #(
  parameter int unsigned CORE_COUNT          = 1,
  parameter int unsigned REG_WIDTH           = 12,
  parameter int unsigned DATA_MEM_ADDR_WIDTH = 12,
  parameter int unsigned INS_MEM_ADDR_WIDTH  = 8,
  parameter int unsigned TIME_WIDTH          = 26,
  parameter int unsigned TIMEOUT_CYCLES      = 2**24,
  parameter int unsigned Q_END_LOC           = 7,
  parameter int unsigned R_START_LOC         = 5,
  parameter int unsigned R_END_LOC           = 8
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic                                start,
  input  logic                                reload_imem,
  input  logic                                rx_byte_valid,
  input  logic                                imem_rx_done,
  input  logic                                dmem_rx_done,
  input  logic                                proc_done,
  input  logic                                dmem_tx_done,
  input  logic                                uart_imem_wr_en,
  input  logic [INS_MEM_ADDR_WIDTH-1:0]       uart_imem_addr,
  input  logic [INS_MEM_ADDR_WIDTH-1:0]       proc_imem_addr,
  input  logic                                uart_dmem_wr_en,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0]      uart_dmem_addr,
  input  logic [CORE_COUNT*REG_WIDTH-1:0]     uart_dmem_din,
  input  logic                                proc_dmem_wr_en,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0]      proc_dmem_addr,
  input  logic [CORE_COUNT*REG_WIDTH-1:0]     proc_dmem_din,
  output logic                                imem_wr_en,
  output logic [INS_MEM_ADDR_WIDTH-1:0]       imem_addr,
  output logic                                dmem_wr_en,
  output logic [DATA_MEM_ADDR_WIDTH-1:0]      dmem_addr,
  output logic [CORE_COUNT*REG_WIDTH-1:0]     dmem_din,
  output logic                                imem_byte_valid,
  output logic                                dmem_byte_valid,
  output logic                                proc_start,
  output logic                                tx_start,
  output logic [DATA_MEM_ADDR_WIDTH-1:0]      rx_end_addr,
  output logic [DATA_MEM_ADDR_WIDTH-1:0]      tx_start_addr,
  output logic [DATA_MEM_ADDR_WIDTH-1:0]      tx_end_addr,
  output logic [2:0]                          state,
  output logic                                busy,
  output logic                                error,
  output logic [TIME_WIDTH-1:0]               run_time,
  output logic [7:0]                          run_count
);

  localparam int unsigned DAW  = DATA_MEM_ADDR_WIDTH;
  localparam int unsigned WDW  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CAPW = (DAW < REG_WIDTH) ? DAW : REG_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_IMEM = 3'd1,
    RX_DMEM = 3'd2,
    EXEC    = 3'd3,
    TX_DMEM = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } stateT;

  stateT            curState;
  logic [WDW-1:0]   wdCount;
  logic [DAW-1:0]   prevDmemAddr;
  logic             active;
  logic             expire;
  logic             phaseDone;
  logic             wdKick;
  logic             leaving;
  logic [DAW-1:0]   capVal;

  assign state  = curState;
  assign busy   = active;
  assign error  = (curState == ERROR);
  // Core-0 lane of the UART data word, zero-extended to an address.
  assign capVal = DAW'(uart_dmem_din[CAPW-1:0]);

  // Phase status: completion pulse of the current phase and watchdog activity.
  always_comb begin
    active    = (curState == RX_IMEM) || (curState == RX_DMEM) ||
                (curState == EXEC)    || (curState == TX_DMEM);
    expire    = active && (wdCount == WDW'(TIMEOUT_CYCLES - 1));
    phaseDone = 1'b0;
    wdKick    = 1'b0;
    case (curState)
      RX_IMEM: begin
        phaseDone = imem_rx_done;
        wdKick    = rx_byte_valid;
      end
      RX_DMEM: begin
        phaseDone = dmem_rx_done;
        wdKick    = rx_byte_valid;
      end
      EXEC:    phaseDone = proc_done;
      TX_DMEM: begin
        phaseDone = dmem_tx_done;
        wdKick    = uart_dmem_wr_en || (uart_dmem_addr != prevDmemAddr);
      end
      default: ;
    endcase
    leaving = active && (expire || phaseDone);
  end

  // Memory port arbitration and start pulses.
  always_comb begin
    imem_wr_en      = 1'b0;
    imem_addr       = '0;
    dmem_wr_en      = 1'b0;
    dmem_addr       = '0;
    dmem_din        = '0;
    imem_byte_valid = 1'b0;
    dmem_byte_valid = 1'b0;
    proc_start      = 1'b0;
    tx_start        = 1'b0;
    case (curState)
      RX_IMEM: begin
        imem_wr_en      = uart_imem_wr_en;
        imem_addr       = uart_imem_addr;
        imem_byte_valid = rx_byte_valid;
      end
      RX_DMEM: begin
        dmem_wr_en      = uart_dmem_wr_en;
        dmem_addr       = uart_dmem_addr;
        dmem_din        = uart_dmem_din;
        dmem_byte_valid = rx_byte_valid;
        proc_start      = dmem_rx_done && !expire;
      end
      EXEC: begin
        dmem_wr_en = proc_dmem_wr_en;
        dmem_addr  = proc_dmem_addr;
        dmem_din   = proc_dmem_din;
        imem_addr  = proc_imem_addr;
        tx_start   = proc_done && !expire;
      end
      TX_DMEM: begin
        dmem_wr_en = uart_dmem_wr_en;
        dmem_addr  = uart_dmem_addr;
        dmem_din   = uart_dmem_din;
      end
      default: ;
    endcase
  end

  // Run FSM; watchdog expiry outranks a same-cycle done pulse.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      curState <= IDLE;
    end else begin
      case (curState)
        IDLE:    if (start) curState <= RX_IMEM;
        RX_IMEM: if (expire) curState <= ERROR; else if (imem_rx_done) curState <= RX_DMEM;
        RX_DMEM: if (expire) curState <= ERROR; else if (dmem_rx_done) curState <= EXEC;
        EXEC:    if (expire) curState <= ERROR; else if (proc_done)    curState <= TX_DMEM;
        TX_DMEM: if (expire) curState <= ERROR; else if (dmem_tx_done) curState <= DONE;
        DONE, ERROR: if (start) curState <= reload_imem ? RX_IMEM : RX_DMEM;
        default: curState <= IDLE;
      endcase
    end
  end

  // Watchdog: restarts on any phase change or sign of link activity.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wdCount      <= '0;
      prevDmemAddr <= '0;
    end else begin
      prevDmemAddr <= uart_dmem_addr;
      if (!active || leaving || wdKick) wdCount <= '0;
      else                              wdCount <= wdCount + WDW'(1);
    end
  end

  // Execution timer and completed-run counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      run_time  <= '0;
      run_count <= '0;
    end else begin
      if (proc_start)                            run_time <= '0;
      else if ((curState == EXEC) && ~&run_time) run_time <= run_time + TIME_WIDTH'(1);
      if ((curState == TX_DMEM) && dmem_tx_done && !expire) run_count <= run_count + 8'd1;
    end
  end

  // Q/R address words snooped from the data-load stream; held across runs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_end_addr   <= '0;
      tx_start_addr <= '0;
      tx_end_addr   <= '0;
    end else if ((curState == RX_DMEM) && uart_dmem_wr_en) begin
      if (uart_dmem_addr == DAW'(Q_END_LOC))   rx_end_addr   <= capVal;
      if (uart_dmem_addr == DAW'(R_START_LOC)) tx_start_addr <= capVal;
      if (uart_dmem_addr == DAW'(R_END_LOC))   tx_end_addr   <= capVal;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: drives two run_sequencer instances with one shared stimulus
// stream. Instance 0: 2 cores, watchdog 1000, 8-bit timer. Instance 1: 1 core,
// watchdog 16, 4-bit timer. Every cycle all outputs of both are compared with a
// phase-level reference model; directed steps add explicit end-of-phase checks.
module tb_run_sequencer;

  logic        clk;
  logic        rstN;
  logic        start, reloadImem, rxByteValid;
  logic        imemRxDone, dmemRxDone, procDone, dmemTxDone;
  logic        uartImemWrEn;
  logic [7:0]  uartImemAddr, procImemAddr;
  logic        uartDmemWrEn, procDmemWrEn;
  logic [11:0] uartDmemAddr, procDmemAddr;
  logic [23:0] uartDmemDin, procDmemDin;

  logic        imemWrEnO[2], dmemWrEnO[2], imemBvO[2], dmemBvO[2];
  logic        procStartO[2], txStartO[2], busyO[2], errorO[2];
  logic [7:0]  imemAddrO[2], runCountO[2];
  logic [11:0] dmemAddrO[2], rxEndO[2], txStartAddrO[2], txEndO[2];
  logic [2:0]  stateO[2];
  logic [23:0] dmemDin0;
  logic [11:0] dmemDin1;
  logic [7:0]  runTime0;
  logic [3:0]  runTime1;

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;

  run_sequencer #(.CORE_COUNT(2), .TIMEOUT_CYCLES(1000), .TIME_WIDTH(8)) u0 (
    .clk(clk), .rstN(rstN), .start(start), .reload_imem(reloadImem),
    .rx_byte_valid(rxByteValid), .imem_rx_done(imemRxDone), .dmem_rx_done(dmemRxDone),
    .proc_done(procDone), .dmem_tx_done(dmemTxDone),
    .uart_imem_wr_en(uartImemWrEn), .uart_imem_addr(uartImemAddr), .proc_imem_addr(procImemAddr),
    .uart_dmem_wr_en(uartDmemWrEn), .uart_dmem_addr(uartDmemAddr), .uart_dmem_din(uartDmemDin),
    .proc_dmem_wr_en(procDmemWrEn), .proc_dmem_addr(procDmemAddr), .proc_dmem_din(procDmemDin),
    .imem_wr_en(imemWrEnO[0]), .imem_addr(imemAddrO[0]),
    .dmem_wr_en(dmemWrEnO[0]), .dmem_addr(dmemAddrO[0]), .dmem_din(dmemDin0),
    .imem_byte_valid(imemBvO[0]), .dmem_byte_valid(dmemBvO[0]),
    .proc_start(procStartO[0]), .tx_start(txStartO[0]),
    .rx_end_addr(rxEndO[0]), .tx_start_addr(txStartAddrO[0]), .tx_end_addr(txEndO[0]),
    .state(stateO[0]), .busy(busyO[0]), .error(errorO[0]),
    .run_time(runTime0), .run_count(runCountO[0])
  );

  run_sequencer #(.CORE_COUNT(1), .TIMEOUT_CYCLES(16), .TIME_WIDTH(4)) u1 (
    .clk(clk), .rstN(rstN), .start(start), .reload_imem(reloadImem),
    .rx_byte_valid(rxByteValid), .imem_rx_done(imemRxDone), .dmem_rx_done(dmemRxDone),
    .proc_done(procDone), .dmem_tx_done(dmemTxDone),
    .uart_imem_wr_en(uartImemWrEn), .uart_imem_addr(uartImemAddr), .proc_imem_addr(procImemAddr),
    .uart_dmem_wr_en(uartDmemWrEn), .uart_dmem_addr(uartDmemAddr), .uart_dmem_din(uartDmemDin[11:0]),
    .proc_dmem_wr_en(procDmemWrEn), .proc_dmem_addr(procDmemAddr), .proc_dmem_din(procDmemDin[11:0]),
    .imem_wr_en(imemWrEnO[1]), .imem_addr(imemAddrO[1]),
    .dmem_wr_en(dmemWrEnO[1]), .dmem_addr(dmemAddrO[1]), .dmem_din(dmemDin1),
    .imem_byte_valid(imemBvO[1]), .dmem_byte_valid(dmemBvO[1]),
    .proc_start(procStartO[1]), .tx_start(txStartO[1]),
    .rx_end_addr(rxEndO[1]), .tx_start_addr(txStartAddrO[1]), .tx_end_addr(txEndO[1]),
    .state(stateO[1]), .busy(busyO[1]), .error(errorO[1]),
    .run_time(runTime1), .run_count(runCountO[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase, watchdog count, timer, run count, captured words.
  typedef struct {
    int st; int wd; int rt; int rc; int rxEnd; int txS; int txE; int prevA;
  } mdlT;
  mdlT m[2];
  mdlT nxt[2];

  function automatic int tmoOf(input int i);
    return (i == 0) ? 1000 : 16;
  endfunction

  function automatic int tmaxOf(input int i);
    return (i == 0) ? 255 : 15;
  endfunction

  function automatic bit isActive(input int st);
    return (st >= 1) && (st <= 4);
  endfunction

  function automatic bit expOf(input int i);
    return isActive(m[i].st) && (m[i].wd == tmoOf(i) - 1);
  endfunction

  function automatic mdlT nextOf(input int i);
    mdlT c;
    mdlT n;
    bit  e;
    int  low;
    c = m[i];
    n = c;
    e = expOf(i);
    if (!rstN) begin
      n = '{default: 0};
      return n;
    end
    case (c.st)
      0: if (start) n.st = 1;
      1: n.st = e ? 6 : (imemRxDone ? 2 : 1);
      2: n.st = e ? 6 : (dmemRxDone ? 3 : 2);
      3: n.st = e ? 6 : (procDone   ? 4 : 3);
      4: n.st = e ? 6 : (dmemTxDone ? 5 : 4);
      5, 6: if (start) n.st = reloadImem ? 1 : 2;
      default: n.st = 0;
    endcase
    if (!isActive(c.st) || n.st != c.st)                    n.wd = 0;
    else if ((c.st == 1 || c.st == 2) && rxByteValid)        n.wd = 0;
    else if (c.st == 4 && (uartDmemWrEn || int'(uartDmemAddr) != c.prevA)) n.wd = 0;
    else                                                     n.wd = c.wd + 1;
    n.prevA = int'(uartDmemAddr);
    if (c.st == 2 && dmemRxDone && !e)            n.rt = 0;
    else if (c.st == 3 && c.rt < tmaxOf(i))       n.rt = c.rt + 1;
    if (c.st == 4 && n.st == 5)                   n.rc = (c.rc + 1) % 256;
    if (c.st == 2 && uartDmemWrEn) begin
      low = int'(uartDmemDin[11:0]);
      if (uartDmemAddr == 12'd7) n.rxEnd = low;
      if (uartDmemAddr == 12'd5) n.txS   = low;
      if (uartDmemAddr == 12'd8) n.txE   = low;
    end
    return n;
  endfunction

  task automatic chk(input int i, input string name, input logic [31:0] o, input logic [31:0] e);
    nTests++;
    assert (o === e) else begin
      nFail++;
      $error("FAIL i%0d.%s cyc=%0d observed=%0h expected=%0h", i, name, cyc, o, e);
    end
  endtask

  // Compare every output of instance i with the model's view of this cycle.
  task automatic checkInst(input int i);
    int st;
    bit e;
    bit eDW, eIW;
    logic [11:0] eDA;
    logic [23:0] eDin;
    logic [7:0]  eIA;
    logic [31:0] oDin, oRt;
    st   = m[i].st;
    e    = expOf(i);
    eDW  = 1'b0; eDA = '0; eDin = '0; eIA = '0;
    if (st == 2 || st == 4) begin
      eDW = uartDmemWrEn; eDA = uartDmemAddr; eDin = uartDmemDin;
    end else if (st == 3) begin
      eDW = procDmemWrEn; eDA = procDmemAddr; eDin = procDmemDin;
    end
    if (i == 1) eDin = eDin & 24'hFFF;
    if (st == 1)      eIA = uartImemAddr;
    else if (st == 3) eIA = procImemAddr;
    eIW = (st == 1) && uartImemWrEn;
    if (i == 0) begin oDin = 32'(dmemDin0); oRt = 32'(runTime0); end
    else        begin oDin = 32'(dmemDin1); oRt = 32'(runTime1); end
    chk(i, "state",      32'(stateO[i]),       32'(st));
    chk(i, "busy",       32'(busyO[i]),        32'(isActive(st)));
    chk(i, "error",      32'(errorO[i]),       32'(st == 6));
    chk(i, "run_time",   oRt,                  32'(m[i].rt));
    chk(i, "run_count",  32'(runCountO[i]),    32'(m[i].rc));
    chk(i, "rx_end",     32'(rxEndO[i]),       32'(m[i].rxEnd));
    chk(i, "tx_s_addr",  32'(txStartAddrO[i]), 32'(m[i].txS));
    chk(i, "tx_e_addr",  32'(txEndO[i]),       32'(m[i].txE));
    chk(i, "imem_wr_en", 32'(imemWrEnO[i]),    32'(eIW));
    chk(i, "imem_addr",  32'(imemAddrO[i]),    32'(eIA));
    chk(i, "dmem_wr_en", 32'(dmemWrEnO[i]),    32'(eDW));
    chk(i, "dmem_addr",  32'(dmemAddrO[i]),    32'(eDA));
    chk(i, "dmem_din",   oDin,                 32'(eDin));
    chk(i, "imem_bv",    32'(imemBvO[i]),      32'((st == 1) && rxByteValid));
    chk(i, "dmem_bv",    32'(dmemBvO[i]),      32'((st == 2) && rxByteValid));
    chk(i, "proc_start", 32'(procStartO[i]),   32'((st == 2) && dmemRxDone && !e));
    chk(i, "tx_start",   32'(txStartO[i]),     32'((st == 3) && procDone && !e));
  endtask

  // One clock: check before the edge, advance the model, then drop the pulses.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) checkInst(i);
    for (int i = 0; i < 2; i++) nxt[i] = nextOf(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) m[i] = nxt[i];
    cyc++;
    start = 1'b0; rxByteValid = 1'b0;
    imemRxDone = 1'b0; dmemRxDone = 1'b0; procDone = 1'b0; dmemTxDone = 1'b0;
  endtask

  task automatic asyncReset();
    rstN = 1'b0;
    for (int i = 0; i < 2; i++) m[i] = '{default: 0};
    #1;
    for (int i = 0; i < 2; i++) checkInst(i);
    cycle();
    rstN = 1'b1;
  endtask

  task automatic dmemWrite(input logic [11:0] a, input logic [11:0] v);
    uartDmemWrEn = 1'b1;
    uartDmemAddr = a;
    uartDmemDin  = {12'($urandom), v};
    procDmemWrEn = 1'b1;
    rxByteValid  = 1'b1;
    cycle();
  endtask

  logic [11:0] capA[4];
  logic [11:0] capV[4];

  initial begin
    rstN = 1'b0;
    start = 1'b0; reloadImem = 1'b0; rxByteValid = 1'b0;
    imemRxDone = 1'b0; dmemRxDone = 1'b0; procDone = 1'b0; dmemTxDone = 1'b0;
    uartImemWrEn = 1'b0; uartImemAddr = '0; procImemAddr = '0;
    uartDmemWrEn = 1'b0; uartDmemAddr = '0; uartDmemDin = '0;
    procDmemWrEn = 1'b0; procDmemAddr = '0; procDmemDin = '0;
    for (int i = 0; i < 2; i++) m[i] = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) checkInst(i);
    cycle();
    rstN = 1'b1;
    repeat (2) cycle();

    // Full run with a 100-cycle execution.
    start = 1'b1;
    cycle();
    chk(0, "run1.rx_imem", 32'(stateO[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      uartImemWrEn = 1'b1; uartImemAddr = 8'($urandom); procImemAddr = 8'($urandom);
      rxByteValid = 1'b1;
      cycle();
    end
    uartImemWrEn = 1'b0;
    imemRxDone = 1'b1;
    cycle();
    chk(0, "run1.rx_dmem", 32'(stateO[0]), 32'd2);
    dmemWrite(12'd5, 12'h010);
    dmemWrite(12'd7, 12'h00F);
    dmemWrite(12'd8, 12'h013);
    dmemWrite(12'($urandom_range(20, 4000)), 12'($urandom));
    uartDmemWrEn = 1'b0; procDmemWrEn = 1'b0;
    dmemRxDone = 1'b1;
    cycle();
    chk(0, "run1.exec", 32'(stateO[0]), 32'd3);
    // uart write enable stays high through execution; only proc_* may reach the port
    for (int k = 1; k <= 100; k++) begin
      uartDmemWrEn = 1'b1; uartDmemAddr = 12'($urandom);
      procDmemWrEn = 1'($urandom); procDmemAddr = 12'($urandom); procDmemDin = 24'($urandom);
      procImemAddr = 8'($urandom);
      if (k == 100) procDone = 1'b1;
      cycle();
    end
    uartDmemWrEn = 1'b0; procDmemWrEn = 1'b0;
    chk(0, "run1.tx", 32'(stateO[0]), 32'd4);
    chk(0, "run1.run_time", 32'(runTime0), 32'd100);
    for (int k = 0; k < 5; k++) begin
      uartDmemAddr = 12'($urandom); uartDmemWrEn = 1'($urandom);
      cycle();
    end
    uartDmemWrEn = 1'b0;
    dmemTxDone = 1'b1;
    cycle();
    chk(0, "run1.done",      32'(stateO[0]),       32'd5);
    chk(0, "run1.run_count", 32'(runCountO[0]),    32'd1);
    chk(0, "run1.tx_s_addr", 32'(txStartAddrO[0]), 32'h010);
    chk(0, "run1.rx_end",    32'(rxEndO[0]),       32'h00F);
    chk(0, "run1.tx_e_addr", 32'(txEndO[0]),       32'h013);
    chk(1, "run1.wd_error",  32'(stateO[1]),       32'd6);

    // Rerun without instruction reload.
    reloadImem = 1'b0; uartImemWrEn = 1'b1;
    start = 1'b1;
    cycle();
    chk(0, "run2.rx_dmem", 32'(stateO[0]), 32'd2);
    chk(1, "run2.rx_dmem", 32'(stateO[1]), 32'd2);
    chk(0, "run2.imem_we", 32'(imemWrEnO[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      capA[k] = (k < 3) ? 12'(5 + k) : 12'($urandom);
      capV[k] = 12'($urandom);
      dmemWrite(capA[k], capV[k]);
    end
    uartDmemWrEn = 1'b0; procDmemWrEn = 1'b0; uartImemWrEn = 1'b0;
    chk(0, "run2.rx_end", 32'(rxEndO[0]), 32'(capV[2]));
    dmemRxDone = 1'b1;
    cycle();
    for (int k = 1; k <= 10; k++) begin
      procDmemAddr = 12'($urandom); procDmemDin = 24'($urandom);
      if (k == 10) procDone = 1'b1;
      cycle();
    end
    chk(0, "run2.run_time", 32'(runTime0), 32'd10);
    // Moving addresses keep the short watchdog alive in TX_DMEM.
    for (int k = 0; k < 20; k++) begin
      uartDmemAddr = uartDmemAddr + 12'd1;
      cycle();
    end
    dmemTxDone = 1'b1;
    cycle();
    chk(0, "run2.run_count", 32'(runCountO[0]), 32'd2);
    chk(1, "run2.run_count", 32'(runCountO[1]), 32'd1);
    chk(1, "run2.done",      32'(stateO[1]),    32'd5);

    // Watchdog on a silent instruction load.
    reloadImem = 1'b1;
    start = 1'b1;
    cycle();
    repeat (15) cycle();
    chk(1, "wd.before", 32'(stateO[1]), 32'd1);
    cycle();
    chk(1, "wd.error_state", 32'(stateO[1]), 32'd6);
    chk(1, "wd.error_flag",  32'(errorO[1]), 32'd1);
    chk(0, "wd.long_alive",  32'(stateO[0]), 32'd1);
    start = 1'b1;
    cycle();
    chk(1, "wd.restart", 32'(stateO[1]), 32'd1);
    chk(1, "wd.clear",   32'(errorO[1]), 32'd0);
    chk(0, "wd.ignored", 32'(stateO[0]), 32'd1);

    // Timer saturation; expiry outranks a same-cycle proc_done.
    imemRxDone = 1'b1;
    cycle();
    dmemRxDone = 1'b1;
    cycle();
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) procDone = 1'b1;
      cycle();
    end
    chk(1, "sat.run_time", 32'(runTime1),  32'd15);
    chk(1, "sat.error",    32'(stateO[1]), 32'd6);
    chk(0, "sat.tx",       32'(stateO[0]), 32'd4);
    chk(0, "sat.run_time", 32'(runTime0),  32'd16);
    dmemTxDone = 1'b1;
    cycle();
    reloadImem = 1'b0;
    start = 1'b1;
    cycle();
    dmemRxDone = 1'b1;
    cycle();
    repeat (300) cycle();
    chk(0, "sat.run_time8", 32'(runTime0),  32'd255);
    chk(0, "sat.exec",      32'(stateO[0]), 32'd3);

    // Reset in the middle of execution.
    asyncReset();
    chk(0, "rst.state",     32'(stateO[0]),       32'd0);
    chk(0, "rst.run_count", 32'(runCountO[0]),    32'd0);
    chk(0, "rst.tx_s_addr", 32'(txStartAddrO[0]), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      start        = ($urandom_range(0, 19) == 0);
      reloadImem   = 1'($urandom);
      rxByteValid  = ($urandom_range(0, 2) == 0);
      imemRxDone   = ($urandom_range(0, 11) == 0);
      dmemRxDone   = ($urandom_range(0, 11) == 0);
      procDone     = ($urandom_range(0, 11) == 0);
      dmemTxDone   = ($urandom_range(0, 11) == 0);
      uartImemWrEn = 1'($urandom);
      uartImemAddr = 8'($urandom);
      procImemAddr = 8'($urandom);
      uartDmemWrEn = 1'($urandom);
      uartDmemAddr = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(4, 9));
      uartDmemDin  = 24'($urandom);
      procDmemWrEn = 1'($urandom);
      procDmemAddr = 12'($urandom);
      procDmemDin  = 24'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
